// File: rtl/hub_pkg.sv
`default_nettype none
// ============================================================================
// Package  : hub_pkg
// Brief    : Shared constants and byte-lane helper for the hub access path.
// Revision : 1.0 - initial release
// ============================================================================
package hub_pkg;

  // Transfer size codes as presented on req_sz (2 bits per cog)
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_WORD = 2'b01;
  localparam logic [1:0] SZ_LONG = 2'b10;  // any code with bit 1 set is a long

  // Number of hub windows in one rotation
  localparam int HUB_SLOTS = 8;

  // Byte-address bit that selects the ROM half ($8000..$FFFF)
  localparam int ROM_BASE_BIT = 15;

  // Byte-lane enables for a transfer of size sz at byte offset alo
  function automatic logic [3:0] lane_mask(input logic [1:0] sz,
                                           input logic [1:0] alo);
    logic [3:0] mask;
    if (sz[1]) begin
      mask = 4'b1111;
    end else if (sz == SZ_WORD) begin
      mask = alo[1] ? 4'b1100 : 4'b0011;
    end else begin
      mask = 4'b0001 << alo;
    end
    return mask;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hub_lane_align.sv
`default_nettype none
// ============================================================================
// Module   : hub_lane_align
// Brief    : Combinational byte-lane alignment. WRITE=1 replicates right-
//            justified write data across the long and builds lane enables;
//            WRITE=0 shifts and zero-extends a long read into a right-
//            justified byte/word/long.
// Revision : 1.0 - initial release
// ============================================================================
module hub_lane_align
  import hub_pkg::*;
#(
  parameter bit WRITE = 1'b1
) (
  input  logic [1:0]  sz_i,
  input  logic [1:0]  alo_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic [3:0]  wb_o
);

  generate
    if (WRITE) begin : g_write
      // Replicate the low byte/word into every lane the memory may write
      always_comb begin
        wb_o   = lane_mask(sz_i, alo_i);
        data_o = data_i;
        if (!sz_i[1]) begin
          if (sz_i == SZ_WORD) begin
            data_o = {2{data_i[15:0]}};
          end else begin
            data_o = {4{data_i[7:0]}};
          end
        end
      end
    end else begin : g_read
      // Shift the addressed lane(s) down to bit 0 and clear the rest
      always_comb begin
        logic [31:0] shifted;
        wb_o    = lane_mask(sz_i, alo_i);
        data_o  = data_i;
        shifted = '0;
        if (!sz_i[1]) begin
          if (sz_i == SZ_WORD) begin
            shifted = data_i >> {alo_i[1], 4'b0000};
            data_o  = {16'h0000, shifted[15:0]};
          end else begin
            shifted = data_i >> {alo_i, 3'b000};
            data_o  = {24'h000000, shifted[7:0]};
          end
        end
      end
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/hub_slot_seq.sv
`default_nettype none
// ============================================================================
// Module   : hub_slot_seq
// Brief    : Round-robin hub sequencer. Each cog owns a two-cycle window
//            (phase 0 issue, phase 1 completion) out of every sixteen; the
//            access is converted to one long-wide memory cycle and the lane-
//            extracted result is returned with a one-cycle ack.
// Revision : 1.0 - initial release
// ============================================================================
module hub_slot_seq
  import hub_pkg::*;
#(
  parameter int COGS = 8  // only 8 is supported; port widths assume it
) (
  input  logic         clk_cog,
  input  logic         res,
  input  logic [7:0]   req,
  input  logic [7:0]   req_w,
  input  logic [15:0]  req_sz,
  input  logic [127:0] req_a,
  input  logic [255:0] req_d,
  output logic [7:0]   ack,
  output logic [31:0]  rdata,
  output logic         ena_bus,
  output logic         w,
  output logic [3:0]   wb,
  output logic [13:0]  a,
  output logic [31:0]  d,
  input  logic [31:0]  q
);

  localparam int SLOT_W = $clog2(COGS);

  // Rotation state
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic              phase_q, phase_d;

  // One-entry pipeline: the access issued last cycle, completing this cycle
  logic              pv_q, pv_d;
  logic [SLOT_W-1:0] pipe_cog_q, pipe_cog_d;
  logic              pipe_wr_q, pipe_wr_d;
  logic [1:0]        pipe_sz_q, pipe_sz_d;
  logic [1:0]        pipe_alo_q, pipe_alo_d;

  // Completion outputs
  logic [7:0]        ack_q, ack_d;
  logic [31:0]       rdata_q, rdata_d;

  // Fields of the cog owning the current window
  logic              w_req;
  logic              w_wr;
  logic [1:0]        w_sz;
  logic [15:0]       w_addr;
  logic [31:0]       w_data;
  logic              w_issue;

  // Lane-aligned data in both directions
  logic [31:0]       w_wr_data;
  logic [3:0]        w_wr_lanes;
  logic [31:0]       w_rd_data;
  logic [3:0]        w_rd_lanes_unused;

  // Completion is identical for reads and writes; the flag is kept with the
  // access so a debug probe can tell them apart.
  logic              w_pipe_wr_unused;
  assign w_pipe_wr_unused = pipe_wr_q;

  assign w_req  = req[slot_q];
  assign w_wr   = req_w[slot_q];
  assign w_sz   = req_sz[{slot_q, 1'b0} +: 2];
  assign w_addr = req_a[{slot_q, 4'b0000} +: 16];
  assign w_data = req_d[{slot_q, 5'b00000} +: 32];

  // Reset gates the issue so the memory port is quiet the moment res rises
  assign w_issue = ~res & ~phase_q & w_req;

  hub_lane_align #(.WRITE(1'b1)) u_wr_align (
    .sz_i   (w_sz),
    .alo_i  (w_addr[1:0]),
    .data_i (w_data),
    .data_o (w_wr_data),
    .wb_o   (w_wr_lanes)
  );

  hub_lane_align #(.WRITE(1'b0)) u_rd_align (
    .sz_i   (pipe_sz_q),
    .alo_i  (pipe_alo_q),
    .data_i (q),
    .data_o (w_rd_data),
    .wb_o   (w_rd_lanes_unused)
  );

  // Memory port: driven only during an issue cycle, zero otherwise
  always_comb begin
    ena_bus = 1'b0;
    w       = 1'b0;
    wb      = 4'b0000;
    a       = '0;
    d       = '0;
    if (w_issue) begin
      ena_bus = 1'b1;
      w       = w_wr & ~w_addr[ROM_BASE_BIT];  // ROM writes are dropped but acked
      wb      = w_wr_lanes;
      a       = w_addr[15:2];
      d       = w_wr_data;
    end
  end

  // Phase toggles every cycle; slot advances as phase wraps 1 -> 0
  always_comb begin
    phase_d = ~phase_q;
    slot_d  = slot_q;
    if (phase_q) begin
      slot_d = (slot_q == SLOT_W'(HUB_SLOTS - 1)) ? '0 : slot_q + 1'b1;
    end
  end

  // Capture the issued access; valid only if something actually went out
  always_comb begin
    pv_d       = w_issue;
    pipe_cog_d = pipe_cog_q;
    pipe_wr_d  = pipe_wr_q;
    pipe_sz_d  = pipe_sz_q;
    pipe_alo_d = pipe_alo_q;
    if (w_issue) begin
      pipe_cog_d = slot_q;
      pipe_wr_d  = w_wr;
      pipe_sz_d  = w_sz;
      pipe_alo_d = w_addr[1:0];
    end
  end

  // Completion: register extracted q and pulse the owner's ack bit once
  always_comb begin
    ack_d   = 8'h00;
    rdata_d = rdata_q;
    if (pv_q && phase_q) begin
      ack_d   = 8'h01 << pipe_cog_q;
      rdata_d = w_rd_data;
    end
  end

  // State registers; reset abandons any access in flight
  always_ff @(posedge clk_cog or posedge res) begin
    if (res) begin
      slot_q     <= '0;
      phase_q    <= 1'b0;
      pv_q       <= 1'b0;
      pipe_cog_q <= '0;
      pipe_wr_q  <= 1'b0;
      pipe_sz_q  <= 2'b00;
      pipe_alo_q <= 2'b00;
      ack_q      <= 8'h00;
      rdata_q    <= 32'h0;
    end else begin
      slot_q     <= slot_d;
      phase_q    <= phase_d;
      pv_q       <= pv_d;
      pipe_cog_q <= pipe_cog_d;
      pipe_wr_q  <= pipe_wr_d;
      pipe_sz_q  <= pipe_sz_d;
      pipe_alo_q <= pipe_alo_d;
      ack_q      <= ack_d;
      rdata_q    <= rdata_d;
    end
  end

  assign ack   = ack_q;
  assign rdata = rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_hub_slot_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_hub_slot_seq
// Brief    : Directed self-checking bench for hub_slot_seq with a behavioural
//            RAM/ROM model (RAM below $8000, read-only pattern ROM above).
// Revision : 1.0 - initial release
// ============================================================================
module tb_hub_slot_seq;
  import hub_pkg::*;

  logic         clk_cog = 1'b0;
  logic         res;
  logic [7:0]   req;
  logic [7:0]   req_w;
  logic [15:0]  req_sz;
  logic [127:0] req_a;
  logic [255:0] req_d;
  logic [7:0]   ack;
  logic [31:0]  rdata;
  logic         ena_bus;
  logic         w;
  logic [3:0]   wb;
  logic [13:0]  a;
  logic [31:0]  d;
  logic [31:0]  q;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  hub_slot_seq #(.COGS(8)) dut (
    .clk_cog (clk_cog),
    .res     (res),
    .req     (req),
    .req_w   (req_w),
    .req_sz  (req_sz),
    .req_a   (req_a),
    .req_d   (req_d),
    .ack     (ack),
    .rdata   (rdata),
    .ena_bus (ena_bus),
    .w       (w),
    .wb      (wb),
    .a       (a),
    .d       (d),
    .q       (q)
  );

  always #5 clk_cog = ~clk_cog;
  always @(posedge clk_cog) cyc <= cyc + 1;

  // Memory model: synchronous read, read-before-write, ROM ignores writes
  logic [31:0] ram [0:8191];
  logic        pre_en = 1'b0;
  logic [12:0] pre_idx = '0;
  logic [31:0] pre_dat = '0;

  function automatic logic [31:0] rom_word(input logic [13:0] la);
    return 32'h5A00_0000 | {18'h0, la};
  endfunction

  always @(posedge clk_cog) begin
    if (pre_en) ram[pre_idx] = pre_dat;
    if (ena_bus) begin
      if (a[13]) begin
        q <= rom_word(a);
      end else begin
        q <= ram[a[12:0]];
        if (w) for (int b = 0; b < 4; b++) if (wb[b]) ram[a[12:0]][8*b +: 8] = d[8*b +: 8];
      end
    end
  end

  task automatic preload(input logic [15:0] addr, input logic [31:0] val);
    pre_en = 1'b1; pre_idx = addr[14:2]; pre_dat = val;
    @(negedge clk_cog);
    pre_en = 1'b0;
  endtask

  // Drives one access for one cog and reports what the port did; called at a negedge
  task automatic access(input int cog, input bit wr, input logic [1:0] sz,
                        input logic [15:0] addr, input logic [31:0] data,
                        output logic o_w, output logic [3:0] o_wb, output logic [13:0] o_a,
                        output logic [31:0] o_d, output int lat, output logic [31:0] o_rdata,
                        output bit ok);
    int issue_c;
    issue_c = 0; lat = -1; o_rdata = '0; o_w = 1'b0; o_wb = '0; o_a = '0; o_d = '0;
    req_w[cog] = wr; req_sz[2*cog +: 2] = sz; req_a[16*cog +: 16] = addr;
    req_d[32*cog +: 32] = data; req[cog] = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (ena_bus) begin
        o_w = w; o_wb = wb; o_a = a; o_d = d; issue_c = cyc; ok = 1'b1;
        break;
      end
      @(negedge clk_cog);
    end
    if (ok) begin
      ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk_cog); #1;
        if (ack[cog]) begin
          lat = cyc - issue_c; o_rdata = rdata; ok = 1'b1;
          break;
        end
      end
    end
    req[cog] = 1'b0;
    @(negedge clk_cog);
  endtask

  task automatic test_reset;
    int ena_seen, ack_seen;
    res = 1'b1; req = '0; req_w = '0; req_sz = '0; req_a = '0; req_d = '0;
    repeat (2) @(negedge clk_cog);
    #1;
    checks++; if (ack !== 8'h00) begin failures++; $display("FAIL reset_ack got=%h exp=00", ack); end
    checks++; if (rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", rdata); end
    checks++; if ({ena_bus, w, wb, a, d} !== '0) begin failures++;
      $display("FAIL reset_port got ena=%b w=%b wb=%h a=%h d=%h exp all 0", ena_bus, w, wb, a, d); end
    res = 1'b0;
    ena_seen = 0; ack_seen = 0;
    repeat (32) begin
      @(negedge clk_cog); #1;
      if (ena_bus) ena_seen++;
      if (ack != 8'h00) ack_seen++;
    end
    checks++; if (ena_seen != 0) begin failures++; $display("FAIL idle_ena got=%0d exp=0", ena_seen); end
    checks++; if (ack_seen != 0) begin failures++; $display("FAIL idle_ack got=%0d exp=0", ack_seen); end
    @(negedge clk_cog);
  endtask

  task automatic test_long_rw;
    logic ow; logic [3:0] owb; logic [13:0] oa; logic [31:0] od, ord; int lat; bit ok;
    preload(16'h1234, 32'h0000_0000);
    access(3, 1'b1, SZ_LONG, 16'h1234, 32'hDEAD_BEEF, ow, owb, oa, od, lat, ord, ok);
    checks++; if (!ok) begin failures++; $display("FAIL lw_done got=timeout exp=ack"); end
    checks++; if ({ow, owb} !== 5'b1_1111) begin failures++; $display("FAIL lw_w_wb got=%b/%b exp=1/1111", ow, owb); end
    checks++; if (oa !== 14'h048D) begin failures++; $display("FAIL lw_a got=%h exp=048d", oa); end
    checks++; if (od !== 32'hDEAD_BEEF) begin failures++; $display("FAIL lw_d got=%h exp=deadbeef", od); end
    checks++; if (lat != 2) begin failures++; $display("FAIL lw_latency got=%0d exp=2", lat); end
    checks++; if (ord !== 32'h0) begin failures++; $display("FAIL lw_old got=%h exp=0", ord); end
    access(3, 1'b0, SZ_LONG, 16'h1234, 32'h0, ow, owb, oa, od, lat, ord, ok);
    checks++; if (!ok || ow !== 1'b0) begin failures++; $display("FAIL lr_w ok=%0d got=%b exp=0", ok, ow); end
    checks++; if (lat != 2) begin failures++; $display("FAIL lr_latency got=%0d exp=2", lat); end
    checks++; if (ord !== 32'hDEAD_BEEF) begin failures++; $display("FAIL lr_rdata got=%h exp=deadbeef", ord); end
  endtask

  task automatic test_byte_write;
    logic ow; logic [3:0] owb; logic [13:0] oa; logic [31:0] od, ord; int lat; bit ok;
    preload(16'h0100, 32'h1122_3344);
    access(0, 1'b1, SZ_BYTE, 16'h0101, 32'h1234_56AA, ow, owb, oa, od, lat, ord, ok);
    checks++; if (!ok || {ow, owb} !== 5'b1_0010) begin failures++; $display("FAIL bw_w_wb ok=%0d got=%b/%b exp=1/0010", ok, ow, owb); end
    checks++; if (oa !== 14'h0040) begin failures++; $display("FAIL bw_a got=%h exp=0040", oa); end
    checks++; if (od !== 32'hAAAA_AAAA) begin failures++; $display("FAIL bw_d got=%h exp=aaaaaaaa", od); end
    checks++; if (ord !== 32'h0000_0033) begin failures++; $display("FAIL bw_old got=%h exp=00000033", ord); end
    access(0, 1'b0, SZ_LONG, 16'h0100, 32'h0, ow, owb, oa, od, lat, ord, ok);
    checks++; if (!ok || ord !== 32'h1122_AA44) begin failures++; $display("FAIL bw_readback ok=%0d got=%h exp=1122aa44", ok, ord); end
  endtask

  task automatic test_word_read;
    logic ow; logic [3:0] owb; logic [13:0] oa; logic [31:0] od, ord; int lat; bit ok;
    preload(16'h0100, 32'hCAFE_BABE);
    access(5, 1'b0, SZ_WORD, 16'h0102, 32'hFFFF_FFFF, ow, owb, oa, od, lat, ord, ok);
    checks++; if (!ok || ord !== 32'h0000_CAFE) begin failures++; $display("FAIL wr_0102 ok=%0d got=%h exp=0000cafe", ok, ord); end
    checks++; if (ow !== 1'b0 || oa !== 14'h0040) begin failures++; $display("FAIL wr_port got w=%b a=%h exp w=0 a=0040", ow, oa); end
    access(5, 1'b0, SZ_WORD, 16'h0103, 32'h0, ow, owb, oa, od, lat, ord, ok);
    checks++; if (!ok || ord !== 32'h0000_CAFE) begin failures++; $display("FAIL wr_0103 ok=%0d got=%h exp=0000cafe", ok, ord); end
    access(5, 1'b0, SZ_WORD, 16'h0100, 32'h0, ow, owb, oa, od, lat, ord, ok);
    checks++; if (!ok || ord !== 32'h0000_BABE) begin failures++; $display("FAIL wr_0100 ok=%0d got=%h exp=0000babe", ok, ord); end
    access(5, 1'b0, SZ_BYTE, 16'h0103, 32'h0, ow, owb, oa, od, lat, ord, ok);
    checks++; if (!ok || ord !== 32'h0000_00CA) begin failures++; $display("FAIL br_0103 ok=%0d got=%h exp=000000ca", ok, ord); end
  endtask

  // All cogs at once from a fresh rotation: acks 0..7 two cycles apart
  task automatic test_back_to_back;
    logic [7:0]  ack_seq [8];
    logic [31:0] dat_seq [8];
    int          cyc_seq [8];
    int          n, k;
    logic [15:0] ad;
    for (int i = 0; i < 8; i++) begin
      ad = 16'h0200 + 16'(i * 16);
      preload(ad, 32'hA000_0000 + 32'(i) * 32'h0101_0101);
      req_w[i] = 1'b0; req_sz[2*i +: 2] = SZ_LONG; req_a[16*i +: 16] = ad; req_d[32*i +: 32] = '0;
    end
    res = 1'b1; req = 8'hFF;
    #1 res = 1'b0;
    k = cyc; n = 0;
    for (int t = 0; t < 40 && n < 8; t++) begin
      @(negedge clk_cog); #1;
      if (ack != 8'h00) begin
        ack_seq[n] = ack; dat_seq[n] = rdata; cyc_seq[n] = cyc; n++;
        req = req & ~ack;
      end
    end
    req = '0;
    checks++; if (n != 8) begin failures++; $display("FAIL b2b_count got=%0d exp=8", n); end
    for (int i = 0; i < n; i++) begin
      checks++; if (ack_seq[i] !== (8'h01 << i)) begin failures++; $display("FAIL b2b_ack[%0d] got=%h exp=%h", i, ack_seq[i], 8'h01 << i); end
      checks++; if (dat_seq[i] !== 32'hA000_0000 + 32'(i) * 32'h0101_0101) begin failures++;
        $display("FAIL b2b_rdata[%0d] got=%h exp=%h", i, dat_seq[i], 32'hA000_0000 + 32'(i) * 32'h0101_0101); end
      checks++; if (cyc_seq[i] != k + 2 + 2 * i) begin failures++; $display("FAIL b2b_time[%0d] got=%0d exp=%0d", i, cyc_seq[i] - k, 2 + 2 * i); end
    end
    @(negedge clk_cog);
  endtask

  task automatic test_rom;
    logic ow; logic [3:0] owb; logic [13:0] oa; logic [31:0] od, ord; int lat; bit ok;
    access(2, 1'b1, SZ_LONG, 16'hC000, 32'h1234_5678, ow, owb, oa, od, lat, ord, ok);
    checks++; if (!ok) begin failures++; $display("FAIL rom_w_ack got=timeout exp=ack"); end
    checks++; if (ow !== 1'b0) begin failures++; $display("FAIL rom_w_suppress got=%b exp=0", ow); end
    checks++; if (lat != 2) begin failures++; $display("FAIL rom_w_latency got=%0d exp=2", lat); end
    access(2, 1'b0, SZ_LONG, 16'hC000, 32'h0, ow, owb, oa, od, lat, ord, ok);
    checks++; if (!ok || ord !== 32'h5A00_3000) begin failures++; $display("FAIL rom_read ok=%0d got=%h exp=5a003000", ok, ord); end
    access(2, 1'b0, SZ_LONG, 16'hFFFC, 32'h0, ow, owb, oa, od, lat, ord, ok);
    checks++; if (!ok || oa !== 14'h3FFF || ord !== 32'h5A00_3FFF) begin failures++;
      $display("FAIL rom_top ok=%0d a=%h got=%h exp a=3fff rdata=5a003fff", ok, oa, ord); end
  endtask

  // Reset during completion phase: no ack, outputs clear without a clock edge
  task automatic test_reset_abort;
    bit found; int ack_seen;
    req_w[2] = 1'b0; req_sz[5:4] = SZ_LONG; req_a[47:32] = 16'h1234; req[2] = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (ena_bus) begin found = 1'b1; break; end
      @(negedge clk_cog);
    end
    checks++; if (!found) begin failures++; $display("FAIL abort_issue got=timeout exp=issue"); end
    @(negedge clk_cog);
    res = 1'b1;
    #1;
    checks++; if ({ack, rdata} !== '0) begin failures++; $display("FAIL abort_async got ack=%h rdata=%h exp 0", ack, rdata); end
    checks++; if ({ena_bus, w, wb, a, d} !== '0) begin failures++;
      $display("FAIL abort_port got ena=%b w=%b wb=%h a=%h d=%h exp all 0", ena_bus, w, wb, a, d); end
    req[2] = 1'b0;
    #1 res = 1'b0;
    ack_seen = 0;
    repeat (20) begin
      @(negedge clk_cog); #1;
      if (ack != 8'h00) ack_seen++;
    end
    checks++; if (ack_seen != 0) begin failures++; $display("FAIL abort_no_ack got=%0d exp=0", ack_seen); end
    @(negedge clk_cog);
  endtask

  initial begin
    test_reset();
    test_long_rw();
    test_byte_write();
    test_word_read();
    test_back_to_back();
    test_rom();
    test_reset_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
